score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50, giving clocks per digit-scan step minus one.
REQ-002 SHALL have port clk  input  1  system clock; all registers update on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port state  input  2  game state: 0 init, 1 go, 2 jump, 3 over.
REQ-005 SHALL have port gpu_en  input  1  game-running enable.
REQ-006 SHALL have port obstacle_x  input  16  obstacle x position.
REQ-007 SHALL have port score_bcd  output  16  current score, 4 BCD digits, digit 0 in bits [3:0].
REQ-008 SHALL have port hi_bcd  output  16  high score, 4 BCD digits.
REQ-009 SHALL have port new_hi  output  1  high for the whole game-over period when the last game set a new high score.
REQ-010 SHALL have port an  output  4  digit enables, active-low, one-hot.
REQ-011 SHALL have port seg  output  8  segments, active-low; bits [6:0] are g..a and bit 7 is dp.

Function
REQ-012 SHALL register state_prev and obs_prev every clock.
REQ-013 SHALL define "run" as follows: state is in {1,2}, state_prev is in {1,2}, and gpu_en is 1.
REQ-014 SHALL detect a pass when run holds and obstacle_x > obs_prev (the obstacle reload).
REQ-015 SHALL increment score_bcd by 1 in BCD at the clock edge that ends the pass cycle; latency is 1 clock.
REQ-016 SHALL propagate BCD carries: 0009->0010, 0099->0100, 0999->1000.
REQ-017 SHALL saturate score_bcd at 9999.
REQ-018 SHALL clear score_bcd to 0000 when state_prev = 0 and state = 1.
REQ-019 SHALL hold score_bcd unchanged in init and over.
REQ-020 SHALL treat entry to over as state = 3 with state_prev != 3.
REQ-021 SHALL, on entry to over, load hi_bcd with score_bcd and set new_hi = 1 if score_bcd > hi_bcd; otherwise both are unchanged.
REQ-022 SHALL compare score_bcd and hi_bcd as 4-digit BCD magnitudes; equal values do not update hi_bcd.
REQ-023 SHALL clear new_hi on the clock after state leaves 3.
REQ-024 SHALL retain hi_bcd across games; only reset clears it.
REQ-025 SHALL, when a pass and entry to over occur in the same cycle, not count the pass, because state = 3 excludes run.
REQ-026 SHALL count scan_cnt from 0 to SCAN_DIV, then wrap to 0 and advance digit index 0->1->2->3->0.
REQ-027 SHALL show hi_bcd when state = 0 and score_bcd otherwise.
REQ-028 SHALL drive an low only at the bit equal to the digit index.
REQ-029 SHALL blank leading zeros: digits 3..1 show seg = FF when they and all higher digits are 0; digit 0 is always shown.
REQ-030 SHALL light dp (seg[7] = 0) only on digit 0, and only while new_hi = 1.
REQ-031 SHALL register an and seg, so the display lags the digit index by 1 clock.

Reset
REQ-032 SHALL, while rst = 0, force the following regardless of clk: score_bcd 0000, hi_bcd 0000, new_hi 0, an 1111, seg FF, scan_cnt 0, digit index 0, state_prev 0, obs_prev 0.
REQ-033 SHALL start scanning from digit 0 on the first clock after rst rises.
REQ-034 SHALL treat reset asserted mid-game as a full clear, including hi_bcd.

Structure
REQ-035 SHALL place the game-state encodings (INIT, GO, JUMP, OVER) and the SCAN_DIV default in a shared package; the game-control block uses the same package.
REQ-036 SHALL instantiate one combinational sub-module, seg7_decode, mapping a 4-bit BCD digit plus a blank flag to active-low segments.

Verification
REQ-037 SHALL cover: hold rst = 0 for 3 clocks -> an = 1111, seg = FF, score_bcd = 0000, hi_bcd = 0000.
REQ-038 SHALL cover: state = 1 with gpu_en = 1, obstacle_x 24, 16, 8, 240 on successive clocks -> score_bcd = 0001 one clock after 240 is sampled; no other change.
REQ-039 SHALL cover: score_bcd = 0009 plus one pass -> 0010; score_bcd = 9999 plus one pass -> 9999.
REQ-040 SHALL cover: score_bcd = 0012, hi_bcd = 0005, state 1->3 -> hi_bcd = 0012 and new_hi = 1; then 3->0 -> new_hi = 0; then 0->1 -> score_bcd = 0000 and hi_bcd = 0012.
REQ-041 SHALL cover: SCAN_DIV = 2, score_bcd = 0105, state = 1 -> an steps 1110, 1101, 1011, 0111 every 3 clocks; seg shows 5, 0, 1, then FF (digit 3 blanked).
REQ-042 SHALL cover: pass detected in the same cycle as state 2->3 -> score_bcd unchanged; assert rst = 0 mid-game -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared game-state encodings, scan default and BCD helpers
// for the score keeper and game-control logic.
package score_keeper_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    GO   = 2'd1,
    JUMP = 2'd2,
    OVER = 2'd3
  } game_state_t;

  localparam int SCAN_DIV_DEF = 50;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  // Saturating 4-digit BCD increment
  function automatic logic [15:0] bcd_inc(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v == BCD_MAX) begin
      c = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment pattern (g..a),
// all segments dark when blank is set.
module seg7_decode (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7f;
    if (!blank) begin
      case (digit)
        4'd0:    seg = 7'b1000000;
        4'd1:    seg = 7'b1111001;
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1111000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        default: seg = 7'h7f;
      endcase
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Score/high-score tracking for the runner game plus a
// multiplexed 4-digit 7-segment display driver.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  state,
  input  logic        gpu_en,
  input  logic [15:0] obstacle_x,
  output logic [15:0] score_bcd,
  output logic [15:0] hi_bcd,
  output logic        new_hi,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int CW =
    (SCAN_DIV < 1) ? 1 : $clog2(SCAN_DIV + 1);

  game_state_t st;
  game_state_t state_prev;
  logic [15:0] obs_prev;
  logic        run;
  logic        pass;
  logic        start;
  logic        over_entry;

  assign st = game_state_t'(state);

  assign run = (st == GO || st == JUMP)
            && (state_prev == GO || state_prev == JUMP)
            && gpu_en;

  // Obstacle reload: x jumps back up to the right edge
  assign pass       = run && (obstacle_x > obs_prev);
  assign start      = (state_prev == INIT) && (st == GO);
  assign over_entry = (st == OVER) && (state_prev != OVER);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_prev <= INIT;
      obs_prev   <= '0;
      score_bcd  <= '0;
      hi_bcd     <= '0;
      new_hi     <= 1'b0;
    end else begin
      state_prev <= st;
      obs_prev   <= obstacle_x;
      if (start) begin
        score_bcd <= '0;
      end else if (pass) begin
        score_bcd <= bcd_inc(score_bcd);
      end
      // Packed BCD orders the same as its binary image
      if (over_entry && (score_bcd > hi_bcd)) begin
        hi_bcd <= score_bcd;
        new_hi <= 1'b1;
      end else if (st != OVER) begin
        new_hi <= 1'b0;
      end
    end
  end

  logic [CW-1:0] scan_cnt;
  logic [1:0]    idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == CW'(SCAN_DIV)) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  logic [15:0] disp;
  logic [3:0]  dig;
  logic        blank;
  logic [6:0]  font;
  logic        dp;

  assign disp = (st == INIT) ? hi_bcd : score_bcd;
  assign dp   = (idx == 2'd0) && new_hi;

  always_comb begin
    dig   = disp[3:0];
    blank = 1'b0;
    case (idx)
      2'd1: begin
        dig   = disp[7:4];
        blank = (disp[15:4] == 12'd0);
      end
      2'd2: begin
        dig   = disp[11:8];
        blank = (disp[15:8] == 8'd0);
      end
      2'd3: begin
        dig   = disp[15:12];
        blank = (disp[15:12] == 4'd0);
      end
      default: begin
        dig   = disp[3:0];
        blank = 1'b0;
      end
    endcase
  end

  seg7_decode u_dec (
    .digit (dig),
    .blank (blank),
    .seg   (font)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 4'hf;
      seg <= 8'hff;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= {~dp, font};
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: vector table, directed
// corner sequences and random play against a decimal model.
module tb_score_keeper;

  localparam int SD = 2;

  logic        clk;
  logic        rst;
  logic [1:0]  state;
  logic        gpu_en;
  logic [15:0] obstacle_x;
  logic [15:0] score_bcd;
  logic [15:0] hi_bcd;
  logic        new_hi;
  logic [3:0]  an;
  logic [7:0]  seg;

  score_keeper #(.SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .gpu_en     (gpu_en),
    .obstacle_x (obstacle_x),
    .score_bcd  (score_bcd),
    .hi_bcd     (hi_bcd),
    .new_hi     (new_hi),
    .an         (an),
    .seg        (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Decimal-level reference model
  logic [6:0] font [10];
  int pow10 [4];
  int m_score, m_hi, m_prev, m_obs, m_cnt, m_idx;
  bit m_newhi;
  logic [3:0] m_an;
  logic [7:0] m_seg;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10),
            4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic bit playing(input int s);
    return s == 1 || s == 2;
  endfunction

  task automatic model_reset();
    m_score = 0; m_hi = 0; m_prev = 0; m_obs = 0;
    m_cnt = 0; m_idx = 0; m_newhi = 0;
    m_an = 4'hf; m_seg = 8'hff;
  endtask

  task automatic model_step(input int st, input bit en,
                            input int ox);
    int os, oh, oi, val, d;
    bit on, bl;
    os = m_score; oh = m_hi; on = m_newhi; oi = m_idx;
    if (m_prev == 0 && st == 1) m_score = 0;
    else if (playing(st) && playing(m_prev) && en && ox > m_obs)
      m_score = (m_score < 9999) ? m_score + 1 : 9999;
    if (st == 3 && m_prev != 3) begin
      if (os > m_hi) begin
        m_hi = os;
        m_newhi = 1;
      end
    end else if (st != 3) begin
      m_newhi = 0;
    end
    val = (st == 0) ? oh : os;
    d = val / pow10[oi] % 10;
    bl = (oi > 0) && (val < pow10[oi]);
    m_an = 4'hf & ~(4'd1 << oi);
    m_seg = bl ? 8'hff : {~(oi == 0 && on), font[d]};
    m_prev = st; m_obs = ox;
    if (m_cnt == SD) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % 4;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic check_model();
    chk("score", 32'(score_bcd), 32'(to_bcd(m_score)));
    chk("hi", 32'(hi_bcd), 32'(to_bcd(m_hi)));
    chk("new_hi", 32'(new_hi), 32'(m_newhi));
    chk("an", 32'(an), 32'(m_an));
    chk("seg", 32'(seg), 32'(m_seg));
  endtask

  // Called at a negedge; returns at the next negedge
  task automatic step(input int st, input bit en, input int ox);
    state = 2'(st);
    gpu_en = en;
    obstacle_x = 16'(ox);
    @(posedge clk);
    model_step(st, en, ox);
    @(negedge clk);
    check_model();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"}, 32'(an), 32'hf);
    chk({tag, "_seg"}, 32'(seg), 32'hff);
    chk({tag, "_score"}, 32'(score_bcd), 32'h0);
    chk({tag, "_hi"}, 32'(hi_bcd), 32'h0);
    chk({tag, "_new_hi"}, 32'(new_hi), 32'h0);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b0;
    #1 chk_reset_vals("mid_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  st;
    logic        en;
    logic [15:0] ox;
    logic [15:0] score;
    logic [15:0] hi;
    logic        nh;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int ox, cur;
    font = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
             7'b0000000, 7'b0010000};
    pow10 = '{1, 10, 100, 1000};
    tbl[0]  = '{0, 1, 0,   16'h0000, 16'h0000, 0};
    tbl[1]  = '{1, 1, 24,  16'h0000, 16'h0000, 0};
    tbl[2]  = '{1, 1, 16,  16'h0000, 16'h0000, 0};
    tbl[3]  = '{1, 1, 8,   16'h0000, 16'h0000, 0};
    tbl[4]  = '{1, 1, 240, 16'h0001, 16'h0000, 0};
    tbl[5]  = '{2, 1, 232, 16'h0001, 16'h0000, 0};
    tbl[6]  = '{2, 1, 300, 16'h0002, 16'h0000, 0};
    tbl[7]  = '{1, 1, 301, 16'h0003, 16'h0000, 0};
    tbl[8]  = '{1, 0, 400, 16'h0003, 16'h0000, 0};
    tbl[9]  = '{1, 1, 401, 16'h0004, 16'h0000, 0};
    tbl[10] = '{1, 1, 402, 16'h0005, 16'h0000, 0};
    tbl[11] = '{3, 1, 500, 16'h0005, 16'h0005, 1};
    tbl[12] = '{3, 1, 0,   16'h0005, 16'h0005, 1};
    tbl[13] = '{0, 1, 0,   16'h0005, 16'h0005, 0};
    tbl[14] = '{0, 1, 0,   16'h0005, 16'h0005, 0};
    tbl[15] = '{1, 1, 10,  16'h0000, 16'h0005, 0};

    rst = 1'b0;
    state = 2'd0;
    gpu_en = 1'b0;
    obstacle_x = 16'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(int'(tbl[i].st), tbl[i].en, int'(tbl[i].ox));
      chk($sformatf("tbl%0d_score", i), 32'(score_bcd),
          32'(tbl[i].score));
      chk($sformatf("tbl%0d_hi", i), 32'(hi_bcd),
          32'(tbl[i].hi));
      chk($sformatf("tbl%0d_nh", i), 32'(new_hi),
          32'(tbl[i].nh));
    end

    // New high score of 12 over a high of 5
    for (int k = 1; k <= 12; k++) step(1, 1, 20 + k);
    chk("g2_score12", 32'(score_bcd), 32'h0012);
    step(1, 1, 0);
    step(3, 1, 0);
    chk("g2_hi", 32'(hi_bcd), 32'h0012);
    chk("g2_new_hi", 32'(new_hi), 32'h1);
    step(0, 1, 0);
    chk("g2_nh_clr", 32'(new_hi), 32'h0);
    step(1, 1, 0);
    chk("g3_score_clr", 32'(score_bcd), 32'h0000);
    chk("g3_hi_kept", 32'(hi_bcd), 32'h0012);

    // Ramp to 105 checking carries, then watch the scan
    for (int k = 1; k <= 105; k++) begin
      step(1, 1, k);
      if (k == 9) chk("bcd_9", 32'(score_bcd), 32'h0009);
      if (k == 10) chk("bcd_10", 32'(score_bcd), 32'h0010);
      if (k == 100) chk("bcd_100", 32'(score_bcd), 32'h0100);
    end
    chk("score_105", 32'(score_bcd), 32'h0105);
    for (int k = 0; k < 12; k++) begin
      step(1, 1, 0);
      case (an)
        4'b1110: chk("scan_d0", 32'(seg), 32'({1'b1, font[5]}));
        4'b1101: chk("scan_d1", 32'(seg), 32'({1'b1, font[0]}));
        4'b1011: chk("scan_d2", 32'(seg), 32'({1'b1, font[1]}));
        4'b0111: chk("scan_d3", 32'(seg), 32'hff);
        default: chk("scan_an", 32'(an), 32'hf);
      endcase
    end

    // Ramp to saturation
    ox = 0;
    cur = 105;
    while (cur < 9999) begin
      ox++;
      step(1, 1, ox);
      cur++;
      if (cur == 999) chk("bcd_999", 32'(score_bcd), 32'h0999);
      if (cur == 1000) chk("bcd_1000", 32'(score_bcd), 32'h1000);
    end
    chk("score_9999", 32'(score_bcd), 32'h9999);
    step(1, 1, ox + 1);
    chk("saturate", 32'(score_bcd), 32'h9999);

    // Pass coinciding with entry to over is not counted
    step(2, 1, 1);
    step(2, 1, 0);
    step(3, 1, 65535);
    chk("over_pass", 32'(score_bcd), 32'h9999);
    chk("over_hi", 32'(hi_bcd), 32'h9999);
    chk("over_nh", 32'(new_hi), 32'h1);

    step(0, 1, 0);
    step(1, 1, 5);
    step(1, 1, 6);
    chk("pre_rst_score", 32'(score_bcd), 32'h0001);
    mid_reset();

    for (int i = 0; i < 3000; i++) begin
      int st;
      st = int'(state);
      if ($urandom_range(0, 3) == 0) st = $urandom_range(0, 3);
      if ($urandom_range(0, 599) == 0) begin
        mid_reset();
      end else begin
        step(st, ($urandom_range(0, 7) != 0),
             ($urandom_range(0, 1) == 1) ? $urandom_range(0, 65535)
                                         : $urandom_range(0, 300));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
